bp_fe_fetch_buffer: RTL and testbench
=====================================

Name: bp_fe_fetch_buffer

Overview:
Multi-lane fetch buffer between the FE memory stage and the FE queue, for the wide-fetch front end. Accepts fetch packets of fetch_width_p instructions plus a lane-valid mask, holds up to els_p packets, and emits one instruction per cycle in lane order. Redirect flush drops all buffered state in one cycle, so pc_gen can restart fetch without draining.

Parameters:
vaddr_width_p, 39, virtual PC width
instr_width_p, 32, instruction width in bits; PC step per lane is instr_width_p/8
fetch_width_p, 4, instruction lanes per fetch packet (>=1)
els_p, 4, packet entries (>=2, power of two)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
flush_i  in  1  redirect flush, synchronous
fetch_v_i  in  1  input packet valid
fetch_pc_i  in  vaddr_width_p  PC of lane 0
fetch_instr_i  in  fetch_width_p*instr_width_p  lane i at bits [i*instr_width_p +: instr_width_p]
fetch_mask_i  in  fetch_width_p  lane-valid mask
fetch_ready_o  out  1  buffer can accept a packet
instr_v_o  out  1  instruction valid
instr_o  out  instr_width_p  instruction
pc_o  out  vaddr_width_p  instruction PC
last_o  out  1  final valid lane of its packet
instr_ready_i  in  1  consumer accepts

Behaviour:
- One clock; reset is asynchronous and active-low (reset_n_i); all state clears immediately on assertion.
- State: els_p entries {pc, instr lanes, remaining mask}; wptr, rptr (log2 els_p, wrap modulo els_p); count 0..els_p.
- Reset values: count=0, wptr=rptr=0, masks=0. While reset_n_i=0: fetch_ready_o=0, instr_v_o=0, instr_o=0, pc_o=0, last_o=0.
- fetch_ready_o = reset_n_i & ~flush_i & (count != els_p). No accept when full, even with a same-cycle dequeue.
- Enqueue on fetch_v_i & fetch_ready_o. If fetch_mask_i==0, the handshake completes but nothing is stored (count unchanged).
- instr_v_o = (count != 0) & ~flush_i.
- Output lane k = lowest set bit of head remaining mask.
- instr_o = head lane k.
- pc_o = head pc + k*(instr_width_p/8), truncated modulo 2^vaddr_width_p.
- last_o = head remaining mask has exactly one bit set.
- Outputs are 0 when instr_v_o=0.
- Dequeue on instr_v_o & instr_ready_i:
  - Clear bit k.
  - If last_o: pop the entry (rptr+1, count-1).
- Enqueue and pop in the same cycle: count unchanged; pointers advance independently.
- Latency: a packet enqueued in cycle N is visible at the output in cycle N+1 at the earliest. No combinational input-to-output path.
- flush_i=1: outputs forced invalid and fetch_ready_o=0 that cycle. Next cycle count=0, wptr=rptr=0. Flush overrides any enqueue or dequeue in that cycle.
- Instruction data is held stable while instr_v_o=1 and instr_ready_i=0 (valid/ready; no retraction except by flush).
- Assertions (sim only): fetch_width_p >= 1; els_p is a power of two.

Optional Feature:
BP_FE_FETCH_BUFFER_STATS_EN
- Defined: adds output ports hwm_o (clog2(els_p+1) bits) and flushed_lanes_o (32 bits), both reset to 0.
  - hwm_o: maximum count ever reached.
  - flushed_lanes_o: saturating sum of set remaining-mask bits discarded by flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- bp_fe_pkg gets `declare_bp_fe_fetch_buffer_entry_s(vaddr_width_p, instr_width_p, fetch_width_p)` for the entry struct, plus a lane-stride helper constant.
- Sub-module bp_fe_fetch_lane_select: combinational lowest-set-bit priority encoder. Outputs lane index, one-hot, and single-bit flag (drives last_o). Reused by the future decode-side aligner.

Test Plan:
- Single packet, fetch_width_p=4:
  - Stimulus: pc=0x8000_0000, mask=4'b1011, instr_ready_i=1.
  - Response: three instructions at pc 0x80000000, 0x80000004, 0x8000000C; last_o only on the third; instr_v_o=0 afterwards.
- Fill to full:
  - Stimulus: instr_ready_i=0, 5 packets presented back to back.
  - Response: first 4 accepted; fetch_ready_o=0 from cycle 4. Pop one full packet (4 lanes); fetch_ready_o=1 the cycle after the pop.
- Flush mid-packet:
  - Stimulus: 2 packets buffered, head with 2 of 4 lanes consumed; assert flush_i with fetch_v_i=1.
  - Response: input not accepted; instr_v_o=0 that cycle and the next. With stats enabled, flushed_lanes_o=6.
- Zero mask and PC wrap:
  - Zero mask: mask=0 is accepted and count stays 0.
  - Wrap: vaddr_width_p=39, pc=0x7F_FFFF_FFFC, mask=4'b0011 → pc_o 0x7F_FFFF_FFFC then 0x00_0000_0000.
- Async reset mid-stream:
  - Stimulus: drop reset_n_i between clock edges with 3 packets buffered.
  - Response: outputs are 0 immediately. After release, fetch_ready_o=1 and instr_v_o=0, and a new packet is delivered correctly from pointer 0.
- Simultaneous enqueue/pop with pointer wrap:
  - Stimulus: run 20 single-lane packets at full throughput.
  - Response: count constant at 1; outputs appear in order, each one cycle after enqueue.

Source files
------------

// File: rtl/bp_fe_pkg.sv
// -----------------------------------------------------------------------------
// bp_fe_pkg
// Shared front-end definitions for the wide-fetch path.
//   - `BP_FE_DECLARE_FETCH_BUFFER_ENTRY_S(vaddr_width, instr_width, fetch_width)
//     declares bp_fe_fetch_buffer_entry_s {pc, instr lanes, remaining mask}
//     inside the instantiating scope, so each user sizes it from its own params.
//   - bp_fe_lane_stride(): byte distance between adjacent instruction lanes.
// No ports.
// -----------------------------------------------------------------------------
`define BP_FE_DECLARE_FETCH_BUFFER_ENTRY_S(vaddr_width_mp, instr_width_mp, fetch_width_mp) \
    typedef struct packed {                                      \
        logic [(vaddr_width_mp)-1:0]                      pc;    \
        logic [((fetch_width_mp)*(instr_width_mp))-1:0]   instr; \
        logic [(fetch_width_mp)-1:0]                      mask;  \
    } bp_fe_fetch_buffer_entry_s

package bp_fe_pkg;

    localparam int unsigned bp_fe_bits_per_byte_gp = 32'd8;

    // PC increment between lane i and lane i+1 of one fetch packet
    function automatic int unsigned bp_fe_lane_stride(input int unsigned instr_width);
        return instr_width / bp_fe_bits_per_byte_gp;
    endfunction

endpackage

// File: rtl/bp_fe_fetch_buffer_chk.sv
// -----------------------------------------------------------------------------
// bp_fe_fetch_buffer_chk
// Simulation checker for bp_fe_fetch_buffer: parameter legality and the
// occupancy bound.
// Ports:
//   clk_i      in  1          clock
//   reset_n_i  in  1          asynchronous active-low reset
//   i_count    in  cnt_w_lp   buffer occupancy
// -----------------------------------------------------------------------------
module bp_fe_fetch_buffer_chk
#(
    parameter  int fetch_width_p = 4,
    parameter  int els_p         = 4,
    localparam int cnt_w_lp      = $clog2(els_p + 1)
)
(
    input logic                clk_i,
    input logic                reset_n_i,
    input logic [cnt_w_lp-1:0] i_count
);

    // Configuration and occupancy sanity, evaluated every cycle out of reset.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (fetch_width_p >= 1)
                else $error("bp_fe_fetch_buffer: fetch_width_p must be >= 1");
            assert ((els_p >= 2) && ((els_p & (els_p - 1)) == 0))
                else $error("bp_fe_fetch_buffer: els_p must be a power of two >= 2");
            assert (i_count <= cnt_w_lp'(els_p))
                else $error("bp_fe_fetch_buffer: count exceeds els_p");
        end
    end

endmodule

// File: rtl/bp_fe_fetch_lane_select.sv
// -----------------------------------------------------------------------------
// bp_fe_fetch_lane_select
// Combinational lowest-set-bit priority encoder over a lane mask.
// Ports:
//   i_mask    in   width_p    lane mask
//   o_lane    out  lane_w_lp  index of the lowest set bit (0 when mask is 0)
//   o_onehot  out  width_p    one-hot of the lowest set bit (0 when mask is 0)
//   o_single  out  1          mask has exactly one bit set
// -----------------------------------------------------------------------------
module bp_fe_fetch_lane_select
    import bp_fe_pkg::*;
#(
    parameter  int width_p   = 4,
    localparam int lane_w_lp = (width_p > 1) ? $clog2(width_p) : 1
)
(
    input  logic [width_p-1:0]   i_mask,
    output logic [width_p-1:0]   o_onehot,
    output logic [lane_w_lp-1:0] o_lane,
    output logic                 o_single
);

    // Two's-complement trick isolates the lowest set bit without a priority chain.
    assign o_onehot = i_mask & (~i_mask + width_p'(1));

    // Exactly one bit: nonzero and clearing the lowest set bit leaves nothing.
    assign o_single = (i_mask != '0) && ((i_mask & (i_mask - width_p'(1))) == '0);

    // Encode the one-hot vector to a binary lane index.
    always_comb begin
        o_lane = '0;
        for (int i = 0; i < width_p; i++) begin
            o_lane = o_lane | (o_onehot[i] ? lane_w_lp'(i) : {lane_w_lp{1'b0}});
        end
    end

endmodule

// File: rtl/bp_fe_fetch_buffer.sv
// -----------------------------------------------------------------------------
// bp_fe_fetch_buffer
// Multi-lane fetch buffer between the FE memory stage and the FE queue.
// Holds up to els_p fetch packets and emits one instruction per cycle in lane
// order. flush_i drops all buffered state in one cycle.
// Optional: define BP_FE_FETCH_BUFFER_STATS_EN to add hwm_o (peak occupancy)
// and flushed_lanes_o (saturating count of lanes discarded by flush).
// Ports:
//   clk_i, reset_n_i             clock, async active-low reset
//   flush_i                      redirect flush (synchronous)
//   fetch_v_i/fetch_ready_o      packet handshake
//   fetch_pc_i/instr_i/mask_i    packet: lane-0 PC, lanes, lane-valid mask
//   instr_v_o/instr_ready_i      instruction handshake
//   instr_o, pc_o, last_o        instruction, its PC, final lane of its packet
//   hwm_o, flushed_lanes_o       statistics (STATS_EN only)
// -----------------------------------------------------------------------------
module bp_fe_fetch_buffer
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int fetch_width_p = 4,
    parameter int els_p         = 4
)
(
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   flush_i,
    input  logic                                   fetch_v_i,
    input  logic [vaddr_width_p-1:0]               fetch_pc_i,
    input  logic [fetch_width_p*instr_width_p-1:0] fetch_instr_i,
    input  logic [fetch_width_p-1:0]               fetch_mask_i,
    output logic                                   fetch_ready_o,
    output logic                                   instr_v_o,
    output logic [instr_width_p-1:0]               instr_o,
    output logic [vaddr_width_p-1:0]               pc_o,
    output logic                                   last_o,
    input  logic                                   instr_ready_i
`ifdef BP_FE_FETCH_BUFFER_STATS_EN
    ,
    output logic [$clog2(els_p+1)-1:0]             hwm_o,
    output logic [31:0]                            flushed_lanes_o
`endif
);

    localparam int          ptr_w_lp  = $clog2(els_p);
    localparam int          cnt_w_lp  = $clog2(els_p + 1);
    localparam int          lane_w_lp = (fetch_width_p > 1) ? $clog2(fetch_width_p) : 1;
    localparam int unsigned stride_lp = bp_fe_lane_stride(instr_width_p);

    `BP_FE_DECLARE_FETCH_BUFFER_ENTRY_S(vaddr_width_p, instr_width_p, fetch_width_p);

    bp_fe_fetch_buffer_entry_s  r_mem [els_p];
    bp_fe_fetch_buffer_entry_s  w_head;
    logic [ptr_w_lp-1:0]        r_wptr;
    logic [ptr_w_lp-1:0]        r_rptr;
    logic [cnt_w_lp-1:0]        r_count;
    logic [cnt_w_lp-1:0]        w_count_nxt;
    logic [fetch_width_p-1:0]   w_onehot;
    logic [lane_w_lp-1:0]       w_lane;
    logic                       w_single;
    logic                       w_full;
    logic                       w_valid;
    logic                       w_accept;
    logic                       w_enq;
    logic                       w_deq;
    logic                       w_pop;
    logic [vaddr_width_p-1:0]   w_lane_off;

    assign w_head = r_mem[r_rptr];

    bp_fe_fetch_lane_select #(.width_p(fetch_width_p)) u_lane_select (
        .i_mask   (w_head.mask),
        .o_onehot (w_onehot),
        .o_lane   (w_lane),
        .o_single (w_single)
    );

    // Full blocks acceptance even if the head pops this cycle: keeps ready off the dequeue path.
    assign w_full        = (r_count == cnt_w_lp'(els_p));
    assign fetch_ready_o = reset_n_i & ~flush_i & ~w_full;
    assign w_accept      = fetch_v_i & fetch_ready_o;
    // An all-zero mask completes the handshake but carries no instructions.
    assign w_enq         = w_accept & (|fetch_mask_i);
    assign w_valid       = (r_count != '0) & ~flush_i;
    assign w_deq         = w_valid & instr_ready_i;
    assign w_pop         = w_deq & w_single;
    assign w_lane_off    = vaddr_width_p'(w_lane) * vaddr_width_p'(stride_lp);

    // Output mux: head lane selected by the priority encoder, zeroed when idle.
    always_comb begin
        instr_v_o = w_valid;
        if (w_valid) begin
            instr_o = w_head.instr[w_lane*instr_width_p +: instr_width_p];
            pc_o    = w_head.pc + w_lane_off;
            last_o  = w_single;
        end else begin
            instr_o = '0;
            pc_o    = '0;
            last_o  = 1'b0;
        end
    end

    // Next occupancy; flush wins over any enqueue or pop.
    always_comb begin
        w_count_nxt = r_count;
        if (flush_i) begin
            w_count_nxt = '0;
        end else begin
            case ({w_enq, w_pop})
                2'b10:   w_count_nxt = r_count + cnt_w_lp'(1);
                2'b01:   w_count_nxt = r_count - cnt_w_lp'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Entry storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < els_p; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            // Cleared masks keep dead entries from counting as buffered lanes.
            for (int i = 0; i < els_p; i++) begin
                r_mem[i].mask <= '0;
            end
        end else begin
            r_count <= w_count_nxt;
            if (w_enq) begin
                r_mem[r_wptr] <= '{pc: fetch_pc_i, instr: fetch_instr_i, mask: fetch_mask_i};
                r_wptr        <= r_wptr + ptr_w_lp'(1);
            end
            // Enqueue never targets the head slot while it is valid (not full, nonempty).
            if (w_deq) begin
                r_mem[r_rptr].mask <= w_head.mask & ~w_onehot;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ptr_w_lp'(1);
            end
        end
    end

`ifdef BP_FE_FETCH_BUFFER_STATS_EN
    logic [cnt_w_lp-1:0] r_hwm;
    logic [31:0]         r_flushed_lanes;
    logic [31:0]         w_buffered_lanes;
    logic [32:0]         w_flush_sum;

    // Lanes still pending across all entries; dead entries hold a zero mask.
    always_comb begin
        w_buffered_lanes = '0;
        for (int i = 0; i < els_p; i++) begin
            for (int j = 0; j < fetch_width_p; j++) begin
                w_buffered_lanes = w_buffered_lanes + {31'd0, r_mem[i].mask[j]};
            end
        end
        w_flush_sum = {1'b0, r_flushed_lanes} + {1'b0, w_buffered_lanes};
    end

    // Peak-occupancy and saturating flushed-lane counters.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_hwm           <= '0;
            r_flushed_lanes <= '0;
        end else begin
            if (w_count_nxt > r_hwm) begin
                r_hwm <= w_count_nxt;
            end
            if (flush_i) begin
                r_flushed_lanes <= w_flush_sum[32] ? 32'hFFFF_FFFF : w_flush_sum[31:0];
            end
        end
    end

    assign hwm_o           = r_hwm;
    assign flushed_lanes_o = r_flushed_lanes;
`endif

    bp_fe_fetch_buffer_chk #(.fetch_width_p(fetch_width_p), .els_p(els_p)) u_chk (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .i_count   (r_count)
    );

endmodule

// File: tb/tb_bp_fe_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_bp_fe_fetch_buffer
// Directed self-checking bench for bp_fe_fetch_buffer (default parameters).
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_bp_fe_fetch_buffer;

    localparam int VW = 39;
    localparam int IW = 32;
    localparam int FW = 4;
    localparam int EL = 4;

    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic              flush_i;
    logic              fetch_v_i;
    logic [VW-1:0]     fetch_pc_i;
    logic [FW*IW-1:0]  fetch_instr_i;
    logic [FW-1:0]     fetch_mask_i;
    logic              fetch_ready_o;
    logic              instr_v_o;
    logic [IW-1:0]     instr_o;
    logic [VW-1:0]     pc_o;
    logic              last_o;
    logic              instr_ready_i;
`ifdef BP_FE_FETCH_BUFFER_STATS_EN
    logic [2:0]        hwm_o;
    logic [31:0]       flushed_lanes_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    bp_fe_fetch_buffer #(
        .vaddr_width_p (VW),
        .instr_width_p (IW),
        .fetch_width_p (FW),
        .els_p         (EL)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .flush_i       (flush_i),
        .fetch_v_i     (fetch_v_i),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_instr_i (fetch_instr_i),
        .fetch_mask_i  (fetch_mask_i),
        .fetch_ready_o (fetch_ready_o),
        .instr_v_o     (instr_v_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .last_o        (last_o),
        .instr_ready_i (instr_ready_i)
`ifdef BP_FE_FETCH_BUFFER_STATS_EN
        ,
        .hwm_o           (hwm_o),
        .flushed_lanes_o (flushed_lanes_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lane i of the packet carries base+i.
    task automatic drive(input logic v, input logic [VW-1:0] pc, input logic [31:0] base,
                         input logic [FW-1:0] mask);
        fetch_v_i     = v;
        fetch_pc_i    = pc;
        fetch_mask_i  = mask;
        fetch_instr_i = {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endtask

    task automatic expect_out(input string tag, input logic [VW-1:0] pc, input logic [31:0] ins,
                              input logic last);
        chk({tag, "_v"},    instr_v_o, 64'd1);
        chk({tag, "_pc"},   pc_o,      64'(pc));
        chk({tag, "_ins"},  instr_o,   64'(ins));
        chk({tag, "_last"}, last_o,    64'(last));
    endtask

    initial begin
        int m;
        reset_n_i     = 1'b0;
        flush_i       = 1'b0;
        instr_ready_i = 1'b0;
        drive(1'b0, '0, 32'd0, 4'b0000);

        // ---- reset state ----
        #2;
        chk("rst_ready", fetch_ready_o, 64'd0);
        chk("rst_v",     instr_v_o,     64'd0);
        chk("rst_ins",   instr_o,       64'd0);
        chk("rst_pc",    pc_o,          64'd0);
        chk("rst_last",  last_o,        64'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // ---- T1: single packet, mask 1011 ----
        instr_ready_i = 1'b1;
        drive(1'b1, 39'h00_8000_0000, 32'h1000_0000, 4'b1011);
        #1;
        chk("t1_ready", fetch_ready_o, 64'd1);
        chk("t1_v_empty", instr_v_o, 64'd0);
        @(negedge clk_i);
        drive(1'b0, '0, 32'd0, 4'b0000);
        #1; expect_out("t1_a", 39'h00_8000_0000, 32'h1000_0000, 1'b0);
        @(negedge clk_i);
        #1; expect_out("t1_b", 39'h00_8000_0004, 32'h1000_0001, 1'b0);
        @(negedge clk_i);
        #1; expect_out("t1_c", 39'h00_8000_000C, 32'h1000_0003, 1'b1);
        @(negedge clk_i);
        #1; chk("t1_done", instr_v_o, 64'd0);

        // ---- T2: fill to full with consumer stalled ----
        instr_ready_i = 1'b0;
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 39'h1000 + VW'(j * 32'h100), 32'h2000_0000 + 32'(j * 16), 4'b1111);
            #1;
            chk("t2_ready", fetch_ready_o, (j < 4) ? 64'd1 : 64'd0);
            if (j > 0) expect_out("t2_hold", 39'h1000, 32'h2000_0000, 1'b0);
            @(negedge clk_i);
        end
        // Pop packet 0; packet 4 stays presented only during the popping cycle.
        instr_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(i == 3, 39'h1400, 32'h2000_0040, 4'b1111);
            #1;
            chk("t2_full_ready", fetch_ready_o, 64'd0);
            expect_out("t2_pop", 39'h1000 + VW'(i * 4), 32'h2000_0000 + 32'(i), i == 3);
            @(negedge clk_i);
        end
        drive(1'b0, '0, 32'd0, 4'b0000);
`ifdef BP_FE_FETCH_BUFFER_STATS_EN
        #1; chk("t2_hwm", hwm_o, 64'd4);
`endif
        // Drain packet 1 and two lanes of packet 2.
        for (int i = 0; i < 4; i++) begin
            #1;
            if (i == 0) chk("t2_ready_after_pop", fetch_ready_o, 64'd1);
            expect_out("t2_p1", 39'h1100 + VW'(i * 4), 32'h2000_0010 + 32'(i), i == 3);
            @(negedge clk_i);
        end
        for (int i = 0; i < 2; i++) begin
            #1; expect_out("t2_p2", 39'h1200 + VW'(i * 4), 32'h2000_0020 + 32'(i), 1'b0);
            @(negedge clk_i);
        end

        // ---- T3: flush with 6 lanes pending and a packet offered ----
        flush_i = 1'b1;
        drive(1'b1, 39'h7000, 32'h7000_0000, 4'b1111);
        #1;
        chk("t3_ready", fetch_ready_o, 64'd0);
        chk("t3_v",     instr_v_o,     64'd0);
        chk("t3_ins",   instr_o,       64'd0);
        @(negedge clk_i);
        flush_i = 1'b0;
        drive(1'b0, '0, 32'd0, 4'b0000);
        #1;
        chk("t3_v_next", instr_v_o,     64'd0);
        chk("t3_ready_next", fetch_ready_o, 64'd1);
`ifdef BP_FE_FETCH_BUFFER_STATS_EN
        chk("t3_flushed", flushed_lanes_o, 64'd6);
`endif
        @(negedge clk_i);

        // ---- T4: zero mask, then PC wrap ----
        drive(1'b1, 39'h6000, 32'h6000_0000, 4'b0000);
        #1; chk("t4_zero_ready", fetch_ready_o, 64'd1);
        @(negedge clk_i);
        drive(1'b1, 39'h7F_FFFF_FFFC, 32'h5500_0000, 4'b0011);
        #1; chk("t4_zero_v", instr_v_o, 64'd0);
        @(negedge clk_i);
        drive(1'b0, '0, 32'd0, 4'b0000);
        #1; expect_out("t4_w0", 39'h7F_FFFF_FFFC, 32'h5500_0000, 1'b0);
        @(negedge clk_i);
        #1; expect_out("t4_w1", 39'h00_0000_0000, 32'h5500_0001, 1'b1);
        @(negedge clk_i);
        #1; chk("t4_done", instr_v_o, 64'd0);

        // ---- T5: async reset with 3 packets buffered ----
        instr_ready_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 39'h5000 + VW'(j * 32'h100), 32'h5000_0000 + 32'(j * 16), 4'b1111);
            @(negedge clk_i);
        end
        drive(1'b0, '0, 32'd0, 4'b0000);
        #1; chk("t5_pre_v", instr_v_o, 64'd1);
        #1; reset_n_i = 1'b0;
        #1;
        chk("t5_rst_v",     instr_v_o,     64'd0);
        chk("t5_rst_ins",   instr_o,       64'd0);
        chk("t5_rst_pc",    pc_o,          64'd0);
        chk("t5_rst_last",  last_o,        64'd0);
        chk("t5_rst_ready", fetch_ready_o, 64'd0);
`ifdef BP_FE_FETCH_BUFFER_STATS_EN
        chk("t5_rst_hwm",     hwm_o,           64'd0);
        chk("t5_rst_flushed", flushed_lanes_o, 64'd0);
`endif
        @(negedge clk_i);
        reset_n_i = 1'b1;
        drive(1'b1, 39'h4000, 32'h4400_0000, 4'b0100);
        #1;
        chk("t5_rel_ready", fetch_ready_o, 64'd1);
        chk("t5_rel_v",     instr_v_o,     64'd0);
        @(negedge clk_i);
        drive(1'b0, '0, 32'd0, 4'b0000);
        instr_ready_i = 1'b1;
        #1; expect_out("t5_new", 39'h4008, 32'h4400_0002, 1'b1);
        @(negedge clk_i);
        #1; chk("t5_done", instr_v_o, 64'd0);

        // ---- T6: 20 single-lane packets at full throughput ----
        for (int n = 0; n <= 20; n++) begin
            if (n < 20) begin
                drive(1'b1, 39'h9000_0000 + VW'(n * 16), 32'h3000_0000 + 32'(n * 16),
                      4'(4'b0001 << (n % 4)));
            end else begin
                drive(1'b0, '0, 32'd0, 4'b0000);
            end
            #1;
            chk("t6_ready", fetch_ready_o, 64'd1);
            if (n == 0) begin
                chk("t6_v0", instr_v_o, 64'd0);
            end else begin
                m = n - 1;
                expect_out("t6", 39'h9000_0000 + VW'(m * 16 + (m % 4) * 4),
                           32'h3000_0000 + 32'(m * 16 + (m % 4)), 1'b1);
            end
            @(negedge clk_i);
        end
        #1; chk("t6_done", instr_v_o, 64'd0);
`ifdef BP_FE_FETCH_BUFFER_STATS_EN
        chk("t6_hwm", hwm_o, 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
